// File: rtl/axi_pkg.sv
// Shared types for the AXI interconnect arbiters: FSM state encodings and
// the default master count.
package axi_pkg;

  localparam int NUM_M_DEFAULT = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_M. Returns one-hot and binary index of the winner.
module rr_pick #(
  parameter int NUM_M = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NUM_M-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_M; k++) begin
      j = (int'(ptr) + k) % NUM_M;
      if (!found && req[j]) begin
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// Round-robin write/read arbiter for the shared AXI slave port. Each direction
// holds a registered one-hot grant for a whole transaction.
module axi_rr_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_M = NUM_M_DEFAULT,
  parameter int IDX_W = $clog2(NUM_M)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [NUM_M-1:0] m_awvalid,
  input  logic [NUM_M-1:0] m_arvalid,
  input  logic             s_awvalid,
  input  logic             s_awready,
  input  logic             s_wvalid,
  input  logic             s_wready,
  input  logic             s_wlast,
  input  logic             s_bvalid,
  input  logic             s_bready,
  input  logic             s_arvalid,
  input  logic             s_arready,
  input  logic             s_rvalid,
  input  logic             s_rready,
  input  logic             s_rlast,
  output logic [NUM_M-1:0] wr_grant,
  output logic [IDX_W-1:0] wr_grant_idx,
  output logic             wr_busy,
  output logic [NUM_M-1:0] rd_grant,
  output logic [IDX_W-1:0] rd_grant_idx,
  output logic             rd_busy
);

  wr_state_t        wr_state, wr_state_nx;
  rd_state_t        rd_state, rd_state_nx;
  logic [IDX_W-1:0] wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
  logic [NUM_M-1:0] wr_grant_nx, rd_grant_nx, wr_pick_oh, rd_pick_oh;
  logic [IDX_W-1:0] wr_idx_nx, rd_idx_nx, wr_pick_idx, rd_pick_idx;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_M - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_wr_pick (
    .req(m_awvalid), .ptr(wr_ptr), .onehot(wr_pick_oh), .idx(wr_pick_idx)
  );

  rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_rd_pick (
    .req(m_arvalid), .ptr(rd_ptr), .onehot(rd_pick_oh), .idx(rd_pick_idx)
  );

  // Write path: grant is latched on leaving W_IDLE and frozen until the B handshake
  always_comb begin
    wr_state_nx = wr_state;
    wr_grant_nx = wr_grant;
    wr_idx_nx   = wr_grant_idx;
    wr_ptr_nx   = wr_ptr;
    case (wr_state)
      W_IDLE: if (|m_awvalid) begin
        wr_state_nx = W_ADDR;
        wr_grant_nx = wr_pick_oh;
        wr_idx_nx   = wr_pick_idx;
      end
      W_ADDR: if (s_awvalid && s_awready) wr_state_nx = W_DATA;
      W_DATA: if (s_wvalid && s_wready && s_wlast) wr_state_nx = W_RESP;
      W_RESP: if (s_bvalid && s_bready) begin
        wr_state_nx = W_IDLE;
        wr_grant_nx = '0;
        wr_idx_nx   = '0;
        wr_ptr_nx   = ptr_inc(wr_grant_idx);
      end
      default: wr_state_nx = W_IDLE;
    endcase
  end

  // Read path: released on the RLAST handshake
  always_comb begin
    rd_state_nx = rd_state;
    rd_grant_nx = rd_grant;
    rd_idx_nx   = rd_grant_idx;
    rd_ptr_nx   = rd_ptr;
    case (rd_state)
      R_IDLE: if (|m_arvalid) begin
        rd_state_nx = R_ADDR;
        rd_grant_nx = rd_pick_oh;
        rd_idx_nx   = rd_pick_idx;
      end
      R_ADDR: if (s_arvalid && s_arready) rd_state_nx = R_DATA;
      R_DATA: if (s_rvalid && s_rready && s_rlast) begin
        rd_state_nx = R_IDLE;
        rd_grant_nx = '0;
        rd_idx_nx   = '0;
        rd_ptr_nx   = ptr_inc(rd_grant_idx);
      end
      default: rd_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state     <= W_IDLE;
      wr_grant     <= '0;
      wr_grant_idx <= '0;
      wr_ptr       <= '0;
      wr_busy      <= 1'b0;
      rd_state     <= R_IDLE;
      rd_grant     <= '0;
      rd_grant_idx <= '0;
      rd_ptr       <= '0;
      rd_busy      <= 1'b0;
    end else begin
      wr_state     <= wr_state_nx;
      wr_grant     <= wr_grant_nx;
      wr_grant_idx <= wr_idx_nx;
      wr_ptr       <= wr_ptr_nx;
      wr_busy      <= (wr_state_nx != W_IDLE);
      rd_state     <= rd_state_nx;
      rd_grant     <= rd_grant_nx;
      rd_grant_idx <= rd_idx_nx;
      rd_ptr       <= rd_ptr_nx;
      rd_busy      <= (rd_state_nx != R_IDLE);
    end
  end

endmodule
